// File: rtl/alu_seq_8bit_pkg.sv
// Shared types for the sequenced ALU front-end: function codes, FSM states
// and the settle-counter width.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ALU_NOT = 2'b00,
        ALU_OR  = 2'b01,
        ALU_AND = 2'b10,
        ALU_ADD = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } seq_state_e;

    localparam int CNT_W = 4;

    // Only ADD propagates carry; every other function sees cin=0 and reports cout=0.
    function automatic logic uses_carry(alu_op_e op);
        return op == ALU_ADD;
    endfunction

endpackage

// File: rtl/alu_seq_8bit_if.sv
// Request/response bus of the sequenced ALU, plus the visible accumulator.
interface alu_seq_8bit_if;
    import alu_seq_pkg::*;

    logic       req_valid;
    logic       req_ready;
    alu_op_e    req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cin;
    logic       req_use_acc;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_out;
    logic       rsp_cout;
    logic       rsp_zero;

    logic [7:0] acc;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, req_use_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_cout, rsp_zero, acc
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, req_use_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_cout, rsp_zero, acc
    );

endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: per-bit NOT/OR/AND slices and a ripple-carry adder.
// f is numbered [0:1], so f[0] is the function-code MSB.
module alu_8bit (
    input  logic       cin,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [0:1] f,
    output logic [7:0] out,
    output logic       cout
);

    logic [8:0] w_carry;
    logic [7:0] w_prop;
    logic [7:0] w_sum;
    logic [7:0] w_and;
    logic [7:0] w_or;
    logic [7:0] w_not;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign w_and[i]       = a[i] & b[i];
        assign w_or[i]        = a[i] | b[i];
        assign w_not[i]       = ~a[i];
        assign w_prop[i]      = a[i] ^ b[i];
        assign w_sum[i]       = w_prop[i] ^ w_carry[i];
        assign w_carry[i+1]   = w_and[i] | (w_prop[i] & w_carry[i]);
    end

    always_comb begin
        out = w_not;
        case (f)
            2'b01:   out = w_or;
            2'b10:   out = w_and;
            2'b11:   out = w_sum;
            default: out = w_not;
        endcase
    end

    // The raw adder carry is always exposed; callers mask it for non-ADD functions.
    assign cout = w_carry[8];

endmodule

// File: rtl/alu_seq_8bit.sv
// Sequenced front-end for alu_8bit: latches one request, holds the operands
// for SETTLE_CYCLES edges, then returns the registered result on a handshake.
module alu_seq_8bit #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_8bit_if.slave bus
);
    import alu_seq_pkg::*;

    localparam logic [1:0]       S_IDLE   = IDLE;
    localparam logic [1:0]       S_DRIVE  = DRIVE;
    localparam logic [1:0]       S_RESP   = RESP;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    alu_op_e          r_op;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic             r_cin;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_rspOut;
    logic             r_rspCout;
    logic [7:0]       r_acc;

    logic [0:1]       w_f;
    logic             w_aluCin;
    logic [7:0]       w_aluOut;
    logic             w_aluCout;

    // Whole-vector copy keeps the numeric code across the [0:1] port ordering.
    assign w_f      = r_op;
    assign w_aluCin = uses_carry(r_op) & r_cin;

    alu_8bit u_alu (w_aluCin, r_a, r_b, w_f, w_aluOut, w_aluCout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= ALU_NOT;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_cin     <= 1'b0;
            r_cnt     <= '0;
            r_rspOut  <= 8'h00;
            r_rspCout <= 1'b0;
            r_acc     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_a     <= bus.req_use_acc ? r_acc : bus.req_a;
                        r_b     <= bus.req_b;
                        r_cin   <= bus.req_cin;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == '0) begin
                        r_rspOut  <= w_aluOut;
                        r_rspCout <= uses_carry(r_op) & w_aluCout;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_acc   <= r_rspOut;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_out   = r_rspOut;
    assign bus.rsp_cout  = r_rspCout;
    assign bus.rsp_zero  = (r_rspOut == 8'h00);
    assign bus.acc       = r_acc;

endmodule
